pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised program-counter unit, successor to the single-register PC. Holds the current fetch address and selects the next PC from the following sources:
- sequential increment
- taken branch
- jump
- call
- return

A DEPTH-entry return-address stack (RAS) backs the call and return sources. The unit sits at the front of the fetch stage and drives instruction-memory address and pipeline PC.

Parameters:
WIDTH, 20, PC/address width in bits
INC, 1, sequential increment added per advance (address units)
DEPTH, 4, RAS entries (power of two, >=2)
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
stall  in  1  1 = hold PC and RAS this cycle
branch_taken  in  1  redirect to branch_target
branch_target  in  WIDTH  branch destination
jump  in  1  unconditional redirect to jump_target
call  in  1  push pc+INC, redirect to jump_target
ret  in  1  pop RAS top into PC
jump_target  in  WIDTH  destination for jump/call
clr_err  in  1  clears sticky error flags
pc  out  WIDTH  current PC (registered)
pc_plus  out  WIDTH  pc+INC (combinational from pc)
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == DEPTH
ras_overflow  out  1  sticky: call issued while full
ras_underflow  out  1  sticky: ret issued while empty

Behaviour:
- Reset asserted (reset=0), asynchronous: pc=RESET_VECTOR, RAS pointer=0, count=0, ras_overflow=0, ras_underflow=0. Resulting outputs: ras_empty=1, ras_full=0, pc_plus=RESET_VECTOR+INC. RAS entry contents are don't-care.
- Reset mid-operation: takes effect immediately, no clock required. The first update is on the first rising clk after reset returns to 1.
- All state updates on rising clk with reset=1. A redirect appears on pc one cycle after the edge that samples it.
- stall=1: pc, RAS pointer, RAS count and entries all hold. Control inputs are ignored that cycle, but clr_err is still honoured.
- stall=0, next-PC priority (highest first):
  1. ret
  2. call
  3. jump
  4. branch_taken
  5. sequential (pc+INC)
- Lower-priority requests in the same cycle are discarded. In particular, call+ret together performs ret only.
- ret, count>0: pc<=RAS[ptr-1], ptr decrements, count decrements.
- ret, count==0: pc<=pc+INC, RAS unchanged, ras_underflow<=1.
- call, count<DEPTH: RAS[ptr]<=pc+INC, ptr increments, count increments, pc<=jump_target.
- call, count==DEPTH: circular overwrite of the oldest entry. RAS[ptr]<=pc+INC, ptr increments mod DEPTH, count stays DEPTH, ras_overflow<=1. The redirect to jump_target still occurs.
- Pointer arithmetic is modulo DEPTH. Count is 0..DEPTH, width clog2(DEPTH)+1.
- PC arithmetic is modulo 2^WIDTH: pc=2^WIDTH-INC advances to 0 with no flag. The same wrap applies to pc_plus and to pushed return addresses.
- Targets are taken verbatim; no alignment check.
- Sticky flags: set by their event, cleared by clr_err=1 at a clock edge (stall does not matter). If set and clear occur in the same cycle, set wins.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared package pc_pkg:
  - next-PC source encoding (SRC_SEQ, SRC_BR, SRC_JMP, SRC_CALL, SRC_RET)
  - default WIDTH, INC, RESET_VECTOR constants
- One sub-module, ras_stack: circular LIFO parameterised by WIDTH/DEPTH, with push/pop/full/empty/overflow/underflow.
- pc_unit contains the priority select, the PC register and the sticky-flag logic.

Test Plan:
Use WIDTH=20, INC=1, DEPTH=4, RESET_VECTOR=0 for all scenarios.
- Reset and sequential: hold reset=0 then release, 5 idle clocks -> pc = 0,1,2,3,4,5; ras_empty=1. Assert reset=0 between edges -> pc=0 immediately, with no clock.
- Stall and redirects: at pc=5 assert stall for 2 cycles -> pc stays 5. Then branch_taken with target 0x00100 -> pc=0x00100 next cycle. Then jump and branch_taken in the same cycle (targets 0x00200 / 0x00300) -> pc=0x00200.
- Call/return nesting: from pc=0x10, call target 0x40; from pc=0x40, call target 0x80 -> RAS holds 0x11, 0x41. Then ret -> pc=0x41, then ret -> pc=0x11, ras_empty=1, no flags.
- Overflow: from pc=0x20, 5 consecutive calls, each to target pc+0x10 -> ras_full=1 and ras_overflow=1 after the 5th. The following 4 rets return 0x61, 0x51, 0x41, 0x31 (oldest, 0x21, is lost), then ras_empty=1.
- Underflow and clear: ret on empty at pc=7 -> pc=8, ras_underflow=1 and stays set. clr_err pulse -> 0. clr_err together with ret-on-empty in the same cycle -> flag remains 1.
- Wrap and call+ret: set pc=0xFFFFF via jump, advance -> pc=0x00000. Call from 0xFFFFF pushes 0x00000. call+ret in the same cycle with count=1 -> ret only, pc=pushed value, count=0.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared definitions for the program-counter unit: next-PC
//                source encoding and default geometry constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int PC_WIDTH_DEF        = 20;
    localparam int PC_INC_DEF          = 1;
    localparam int PC_DEPTH_DEF        = 4;
    localparam int PC_RESET_VECTOR_DEF = 0;

    // Next-PC source, listed lowest to highest priority
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_CALL = 3'd3,
        SRC_RET  = 3'd4
    } next_src_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push while full overwrites
//                the oldest entry; a pop while empty leaves state unchanged.
//                overflow/underflow are single-cycle event strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    import pc_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] C_PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] C_CNT_DEPTH = CW'(DEPTH);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign full      = (cnt_q == C_CNT_DEPTH);
    assign empty     = (cnt_q == '0);
    assign overflow  = push & full;
    assign underflow = pop & empty;
    // ptr is a power-of-two index, so the subtraction wraps onto the newest entry
    assign top_data  = mem_q[ptr_q - C_PTR_ONE];

    // Next stack state: push wins over pop; a full push keeps count saturated
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + C_PTR_ONE;
            if (!full) begin
                cnt_d = cnt_q + C_CNT_ONE;
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - C_PTR_ONE;
            cnt_d = cnt_q - C_CNT_ONE;
        end
    end

    // Stack registers; entries are cleared too so no undefined value can leak out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Fetch-stage program counter with prioritised next-PC select
//                (ret > call > jump > branch > sequential), a return-address
//                stack and sticky RAS overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH_DEF,
    parameter int               INC          = PC_INC_DEF,
    parameter int               DEPTH        = PC_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam logic [WIDTH-1:0] C_INC = WIDTH'(INC);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    next_src_e        w_src;
    logic             w_push, w_pop;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_ovf, w_ras_udf;

    assign pc            = pc_q;
    assign pc_plus       = pc_q + C_INC;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = udf_q;

    // Priority encode the requested next-PC source
    always_comb begin
        w_src = SRC_SEQ;
        if (ret) begin
            w_src = SRC_RET;
        end else if (call) begin
            w_src = SRC_CALL;
        end else if (jump) begin
            w_src = SRC_JMP;
        end else if (branch_taken) begin
            w_src = SRC_BR;
        end
    end

    assign w_push = !stall && (w_src == SRC_CALL);
    assign w_pop  = !stall && (w_src == SRC_RET);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (pc_plus),
        .top_data  (w_ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (w_ras_ovf),
        .underflow (w_ras_udf)
    );

    // Next PC and sticky flags; a set in the same cycle as clr_err wins
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            unique case (w_src)
                SRC_RET:          pc_d = ras_empty ? pc_plus : w_ras_top;
                SRC_CALL, SRC_JMP: pc_d = jump_target;
                SRC_BR:           pc_d = branch_target;
                default:          pc_d = pc_plus;
            endcase
        end
        ovf_d = w_ras_ovf | (ovf_q & ~clr_err);
        udf_d = w_ras_udf | (udf_q & ~clr_err);
    end

    // PC and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

endmodule : pc_unit
`default_nettype wire
